// File: rtl/nx_node_msg_arbiter_pkg.sv
// Shared node message type plus arbiter-local constants.
// NXConstants stands in for the codebase package that owns node_message_t.
package NXConstants;

  typedef struct packed {
    logic [1:0]  command;
    logic [5:0]  target_row;
    logic [5:0]  target_col;
    logic [17:0] payload;
  } node_message_t;

endpackage

package nx_node_msg_arbiter_pkg;
  import NXConstants::*;

  localparam int ARB_FIFO_DEPTH = 2;
  localparam int NODE_MSG_W     = $bits(node_message_t);

endpackage

// File: rtl/nx_node_msg_arbiter_fifo.sv
// nx_node_arb_fifo: 2-entry node_message_t elastic buffer, head always in slot0.
module nx_node_arb_fifo
  import NXConstants::*;
  import nx_node_msg_arbiter_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  node_message_t i_data,
  input  logic          i_pop,
  output node_message_t o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_full_next
);

  logic [1:0]    count_q;
  logic [1:0]    count_next;
  node_message_t slot0_q;
  node_message_t slot1_q;
  logic          push_ok;
  logic          pop_ok;

  assign o_full  = (count_q == 2'(ARB_FIFO_DEPTH));
  assign o_empty = (count_q == 2'd0);
  assign o_head  = slot0_q;

  // A full buffer refuses a push even if it is popped in the same cycle.
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  always_comb begin
    count_next = count_q;
    if (push_ok && !pop_ok) begin
      count_next = count_q + 2'd1;
    end else if (pop_ok && !push_ok) begin
      count_next = count_q - 2'd1;
    end
  end

  assign o_full_next = (count_next == 2'(ARB_FIFO_DEPTH));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok && pop_ok) begin
      if (count_q == 2'd1) begin
        slot0_q <= i_data;
      end else begin
        slot0_q <= slot1_q;
        slot1_q <= i_data;
      end
    end else if (push_ok) begin
      if (count_q == 2'd0) begin
        slot0_q <= i_data;
      end else begin
        slot1_q <= i_data;
      end
    end else if (pop_ok) begin
      slot0_q <= slot1_q;
    end
  end

endmodule

// File: rtl/nx_node_msg_arbiter.sv
// Round-robin merge of STREAMS node message streams onto one registered port.
// Optional per-stream grant counters when NX_NODE_ARB_STATS_EN is defined.
module nx_node_msg_arbiter
  import NXConstants::*;
  import nx_node_msg_arbiter_pkg::*;
#(
  parameter int STREAMS = 2,
  parameter int STAT_W  = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  node_message_t [STREAMS-1:0] i_in_data,
  input  logic [STREAMS-1:0]          i_in_valid,
  output logic [STREAMS-1:0]          o_in_ready,
  output node_message_t               o_msg_data,
  output logic                        o_msg_valid,
  input  logic                        i_msg_ready,
  output logic                        o_idle
`ifdef NX_NODE_ARB_STATS_EN
  ,
  output logic [STREAMS*STAT_W-1:0]   o_grant_count
`endif
);

  localparam int GW = $clog2(STREAMS);

  if (STREAMS < 2 || STAT_W < 1) begin : g_param_check
    $error("nx_node_msg_arbiter: STREAMS must be >= 2 and STAT_W >= 1");
  end

  logic [STREAMS-1:0]          push;
  logic [STREAMS-1:0]          pop;
  logic [STREAMS-1:0]          full;
  logic [STREAMS-1:0]          empty;
  logic [STREAMS-1:0]          full_next;
  node_message_t [STREAMS-1:0] head;
  logic [GW-1:0]               last_grant_q;
  logic [GW-1:0]               grant;
  logic                        found;
  logic                        load;
  int                          idx;

  assign push = i_in_valid & o_in_ready;

  for (genvar s = 0; s < STREAMS; s++) begin : g_fifo
    nx_node_arb_fifo u_fifo (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (push[s]),
      .i_data      (i_in_data[s]),
      .i_pop       (pop[s]),
      .o_head      (head[s]),
      .o_full      (full[s]),
      .o_empty     (empty[s]),
      .o_full_next (full_next[s])
    );
  end

  // Ready is a flop so the input side never sees a path from i_msg_ready.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_in_ready <= '0;
    end else begin
      o_in_ready <= ~full_next;
    end
  end

  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 0; k < STREAMS; k++) begin
      idx = (int'(last_grant_q) + 1 + k) % STREAMS;
      if (!found && !empty[idx]) begin
        found = 1'b1;
        grant = GW'(idx);
      end
    end
  end

  assign load = (!o_msg_valid || i_msg_ready) && found;
  assign pop  = load ? (STREAMS'(1) << grant) : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_msg_valid  <= 1'b0;
      o_msg_data   <= '0;
      last_grant_q <= GW'(STREAMS - 1);
    end else if (load) begin
      o_msg_valid  <= 1'b1;
      o_msg_data   <= head[grant];
      last_grant_q <= grant;
    end else if (i_msg_ready) begin
      o_msg_valid  <= 1'b0;
    end
  end

  assign o_idle = (&empty) && !o_msg_valid;

`ifdef NX_NODE_ARB_STATS_EN
  // Saturating grant counters, one per stream.
  for (genvar s = 0; s < STREAMS; s++) begin : g_stats
    logic [STAT_W-1:0] count_q;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        count_q <= '0;
      end else if (load && (grant == GW'(s)) && (count_q != {STAT_W{1'b1}})) begin
        count_q <= count_q + 1'b1;
      end
    end

    assign o_grant_count[s*STAT_W +: STAT_W] = count_q;
  end
`endif

endmodule

// File: tb/tb_nx_node_msg_arbiter.sv
// Self-checking bench for nx_node_msg_arbiter: queue-level model, per-cycle compare,
// directed scenarios; NX_NODE_ARB_STATS_EN enables the grant counter scenario.
module tb_nx_node_msg_arbiter;
  import NXConstants::*;

  localparam int STREAMS = 2;
`ifdef NX_NODE_ARB_STATS_EN
  localparam int STAT_W = 8;
`endif

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  node_message_t [STREAMS-1:0] in_data;
  logic [STREAMS-1:0]          in_valid;
  logic [STREAMS-1:0]          in_ready;
  node_message_t               msg_data;
  logic                        msg_valid;
  logic                        msg_ready;
  logic                        idle;
`ifdef NX_NODE_ARB_STATS_EN
  logic [STREAMS*STAT_W-1:0]   grant_count;
`endif

  always #5 clk = ~clk;

  nx_node_msg_arbiter #(
    .STREAMS (STREAMS)
`ifdef NX_NODE_ARB_STATS_EN
    ,
    .STAT_W  (STAT_W)
`endif
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_data   (in_data),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .o_msg_data  (msg_data),
    .o_msg_valid (msg_valid),
    .i_msg_ready (msg_ready),
    .o_idle      (idle)
`ifdef NX_NODE_ARB_STATS_EN
    ,
    .o_grant_count (grant_count)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Model: each stream is a bounded list of up to two messages plus one output slot.
  logic [31:0]        mb [STREAMS][2];
  int                 mc [STREAMS];
  logic               m_valid = 1'b0;
  logic [31:0]        m_data  = '0;
  logic [STREAMS-1:0] m_ready = '0;
  logic               m_idle  = 1'b1;
  int                 m_last  = STREAMS - 1;
  int                 m_grant;
  logic               m_found;
  int                 acc_total [STREAMS];
  int                 cyc = 0;
  logic [31:0]        out_data [$];
  int                 out_cyc  [$];
  logic               sb_en  = 1'b0;
  int                 sb_next [STREAMS];
  int                 sb_rx  = 0;
  logic               cmp_en = 1'b0;

  initial begin
    for (int s = 0; s < STREAMS; s++) begin
      mc[s] = 0;
      acc_total[s] = 0;
      sb_next[s] = 0;
    end
  end

  task automatic scoreboardCheck(input logic [31:0] d);
    int s;
    s = int'(d[31:24]);
    if (s < STREAMS) begin
      checkOutput("sb_order", d, (32'(s) << 24) | 32'(sb_next[s]));
      sb_next[s]++;
    end else begin
      checkOutput("sb_stream_id", 32'(s), 32'(STREAMS - 1));
    end
    sb_rx++;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int s = 0; s < STREAMS; s++) mc[s] = 0;
      m_valid = 1'b0;
      m_data  = '0;
      m_ready = '0;
      m_last  = STREAMS - 1;
    end else begin
      if (m_valid && msg_ready) begin
        out_data.push_back(m_data);
        out_cyc.push_back(cyc);
        if (sb_en) scoreboardCheck(m_data);
      end
      m_found = 1'b0;
      m_grant = 0;
      for (int k = 0; k < STREAMS; k++) begin
        if (!m_found && mc[(m_last + 1 + k) % STREAMS] > 0) begin
          m_found = 1'b1;
          m_grant = (m_last + 1 + k) % STREAMS;
        end
      end
      if ((!m_valid || msg_ready) && m_found) begin
        m_data = mb[m_grant][0];
        mb[m_grant][0] = mb[m_grant][1];
        mc[m_grant]--;
        m_valid = 1'b1;
        m_last  = m_grant;
      end else if (msg_ready) begin
        m_valid = 1'b0;
      end
      for (int s = 0; s < STREAMS; s++) begin
        if (in_valid[s] && m_ready[s]) begin
          mb[s][mc[s]] = in_data[s];
          mc[s]++;
          acc_total[s]++;
        end
      end
      for (int s = 0; s < STREAMS; s++) m_ready[s] = (mc[s] < 2);
    end
    m_idle = !m_valid;
    for (int s = 0; s < STREAMS; s++) if (mc[s] != 0) m_idle = 1'b0;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("in_ready", 32'(in_ready), 32'(m_ready));
      checkOutput("msg_valid", 32'(msg_valid), 32'(m_valid));
      if (m_valid) checkOutput("msg_data", msg_data, m_data);
      checkOutput("idle", 32'(idle), 32'(m_idle));
    end
  end

  // Stimulus control: mode 0 off, 1 offer continuously, 2 offer randomly.
  int          drv_mode  [STREAMS];
  logic [31:0] drv_base  [STREAMS];
  int          drv_limit [STREAMS];
  int          drv_start [STREAMS];
  logic        rdy_rand  = 1'b0;
  logic        rdy_fixed = 1'b0;

  task automatic applyStimulus();
    int sent;
    for (int s = 0; s < STREAMS; s++) begin
      sent = acc_total[s] - drv_start[s];
      if (drv_mode[s] != 0 && sent < drv_limit[s]) begin
        in_valid[s] = (drv_mode[s] == 1) ? 1'b1 : ($urandom_range(1, 0) == 1);
        in_data[s]  = node_message_t'(drv_base[s] + 32'(sent));
      end else begin
        in_valid[s] = 1'b0;
        in_data[s]  = '0;
      end
    end
    msg_ready = rdy_rand ? ($urandom_range(3, 0) != 0) : rdy_fixed;
  endtask

  task automatic nextCycle();
    @(negedge clk);
    applyStimulus();
  endtask

  task automatic startStream(input int s, input int mode, input logic [31:0] base,
                             input int limit);
    drv_start[s] = acc_total[s];
    drv_mode[s]  = mode;
    drv_base[s]  = base;
    drv_limit[s] = limit;
  endtask

  task automatic stopStreams();
    for (int s = 0; s < STREAMS; s++) drv_mode[s] = 0;
  endtask

  task automatic doReset();
    stopStreams();
    rst = 1'b1;
    applyStimulus();
    nextCycle();
    nextCycle();
    rst = 1'b0;
    nextCycle();
  endtask

  task automatic waitIdle(input string name, input int budget);
    for (int i = 0; i < budget && !(idle && m_idle); i++) nextCycle();
    checkOutput(name, 32'(idle), 32'd1);
  endtask

  initial begin
    in_valid  = '0;
    in_data   = '0;
    msg_ready = 1'b0;
    for (int s = 0; s < STREAMS; s++) begin
      drv_mode[s] = 0; drv_base[s] = '0; drv_limit[s] = 0; drv_start[s] = 0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_msg_valid", 32'(msg_valid), 32'd0);
    checkOutput("reset_msg_data", msg_data, 32'd0);
    checkOutput("reset_idle", 32'(idle), 32'd1);
    cmp_en = 1'b1;
    rst = 1'b0;
    nextCycle();
    checkOutput("ready_after_reset", 32'(in_ready), 32'h3);

    // Single stream A,B,C back-to-back appears on cycles 2,3,4
    rdy_fixed = 1'b1;
    startStream(0, 1, 32'hA, 3);
    applyStimulus();
    nextCycle();
    nextCycle();
    checkOutput("A_c2_valid", 32'(msg_valid), 32'd1);
    checkOutput("A_c2_data", msg_data, 32'hA);
    nextCycle();
    checkOutput("A_c3_data", msg_data, 32'hB);
    nextCycle();
    checkOutput("A_c4_data", msg_data, 32'hC);
    nextCycle();
    checkOutput("A_c5_valid", 32'(msg_valid), 32'd0);
    checkOutput("A_c5_idle", 32'(idle), 32'd1);

    // Two busy streams alternate with no gap
    doReset();
    out_data.delete(); out_cyc.delete();
    startStream(0, 1, 32'h10, 4);
    startStream(1, 1, 32'h20, 4);
    applyStimulus();
    for (int i = 0; i < 40 && out_data.size() < 8; i++) nextCycle();
    checkOutput("B_count", 32'(out_data.size()), 32'd8);
    if (out_data.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        checkOutput("B_order", out_data[i],
                    ((i % 2) == 0 ? 32'h10 : 32'h20) + 32'(i / 2));
        if (i > 0) checkOutput("B_no_gap", 32'(out_cyc[i] - out_cyc[i-1]), 32'd1);
      end
    end
    stopStreams();
    waitIdle("B_idle", 20);

    // Stalled output: only three messages fit
    rdy_fixed = 1'b0;
    out_data.delete(); out_cyc.delete();
    startStream(1, 1, 32'h30, 5);
    applyStimulus();
    repeat (10) nextCycle();
    checkOutput("C_accepted", 32'(acc_total[1] - drv_start[1]), 32'd3);
    checkOutput("C_ready1", 32'(in_ready[1]), 32'd0);
    checkOutput("C_valid", 32'(msg_valid), 32'd1);
    checkOutput("C_held_data", msg_data, 32'h30);
    checkOutput("C_no_out", 32'(out_data.size()), 32'd0);
    stopStreams();
    rdy_fixed = 1'b1;
    applyStimulus();
    for (int i = 0; i < 20 && out_data.size() < 3; i++) nextCycle();
    checkOutput("C_drain_count", 32'(out_data.size()), 32'd3);
    if (out_data.size() >= 3) begin
      for (int i = 0; i < 3; i++) checkOutput("C_drain_order", out_data[i], 32'h30 + 32'(i));
    end
    waitIdle("C_idle", 10);

    // Reset with messages buffered drops everything
    rdy_fixed = 1'b0;
    startStream(0, 1, 32'h40, 3);
    applyStimulus();
    repeat (6) nextCycle();
    checkOutput("D_ready0_full", 32'(in_ready[0]), 32'd0);
    checkOutput("D_busy", 32'(idle), 32'd0);
    stopStreams();
    rst = 1'b1;
    applyStimulus();
    nextCycle();
    nextCycle();
    checkOutput("D_rst_valid", 32'(msg_valid), 32'd0);
    checkOutput("D_rst_idle", 32'(idle), 32'd1);
    checkOutput("D_rst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    rdy_fixed = 1'b1;
    out_data.delete(); out_cyc.delete();
    repeat (5) nextCycle();
    checkOutput("D_no_stale", 32'(out_data.size()), 32'd0);
    checkOutput("D_after_valid", 32'(msg_valid), 32'd0);

`ifdef NX_NODE_ARB_STATS_EN
    // Grant counters saturate
    doReset();
    checkOutput("F_reset_count0", 32'(grant_count[0 +: STAT_W]), 32'd0);
    out_data.delete(); out_cyc.delete();
    startStream(0, 1, 32'h100, 300);
    applyStimulus();
    for (int i = 0; i < 400 && out_data.size() < 300; i++) nextCycle();
    checkOutput("F_out_count", 32'(out_data.size()), 32'd300);
    checkOutput("F_count0_sat", 32'(grant_count[0 +: STAT_W]), 32'd255);
    checkOutput("F_count1", 32'(grant_count[STAT_W +: STAT_W]), 32'd0);
    stopStreams();
    waitIdle("F_idle", 10);
`endif

    // Random traffic, 10k messages, per-stream order and completeness
    out_data.delete(); out_cyc.delete();
    for (int s = 0; s < STREAMS; s++) sb_next[s] = 0;
    sb_rx = 0;
    sb_en = 1'b1;
    for (int s = 0; s < STREAMS; s++) startStream(s, 2, 32'(s) << 24, 5000);
    rdy_rand = 1'b1;
    applyStimulus();
    for (int i = 0; i < 60000 && sb_rx < 10000; i++) begin
      nextCycle();
      if (i % 1000 == 0) begin
        out_data.delete();
        out_cyc.delete();
      end
    end
    checkOutput("E_received", 32'(sb_rx), 32'd10000);
    for (int s = 0; s < STREAMS; s++) checkOutput("E_per_stream", 32'(sb_next[s]), 32'd5000);
    sb_en = 1'b0;
    stopStreams();
    rdy_rand = 1'b0;
    rdy_fixed = 1'b1;
    applyStimulus();
    waitIdle("E_idle", 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
